// File: rtl/clk_div_pkg.sv
// Shared defaults and width helper for the multi-channel clock divider.
package clk_div_pkg;

    localparam int DIV_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 1;

    // Channel-select width; a single-bit select is kept even for one channel.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, 50% square wave, rise tick and a
// single pending-divisor slot that is applied only at a period end.
module clk_div_ch import clk_div_pkg::*; #(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             pending_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q,      cnt_d;
    logic [DIV_W-1:0] div_act_q,  div_act_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pending_q,  pending_d;
    logic             clk_q,      clk_d;
    logic             tick_q,     tick_d;

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pending_q  <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            pend_div_q <= pend_div_d;
            pending_q  <= pending_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        pend_div_d = pend_div_q;
        pending_d  = pending_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;

        if (sync_i || !en_i) begin
            // Idle or realigning: park low and take any pending divisor now.
            cnt_d = '0;
            clk_d = 1'b0;
            if (pending_q) begin
                div_act_d = pend_div_q;
                pending_d = 1'b0;
            end
        end else if (cnt_q >= div_act_q) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
            // Falling edge closes the period; only here may the divisor change.
            if (clk_q && pending_q) begin
                div_act_d = pend_div_q;
                pending_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // The top only strobes load when pending is clear, so it never races an apply.
        if (load_i) begin
            pend_div_d = load_val_i;
            pending_d  = 1'b1;
        end
    end

    assign pending_o = pending_q;
    assign clk_o     = clk_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a valid/ready divisor reload
// port and a global sync that realigns every channel.
module clk_div_multi import clk_div_pkg::*; #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] clk_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] load;

    // Out-of-range selects stay ready and load nothing, so the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        load      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
                load[i]   = cfg_valid & ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_100    (clk_100),
            .rst_n      (rst_n),
            .en_i       (ch_en[g]),
            .sync_i     (sync),
            .load_i     (load[g]),
            .load_val_i (cfg_div),
            .pending_o  (pend[g]),
            .clk_o      (clk_o[g]),
            .tick_o     (tick_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a 2-channel instance for the main checks
// and a 3-channel instance for the out-of-range channel select.
module tb_clk_div_multi;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic [1:0]  ch_en;
    logic        sync;
    logic        cfg_valid;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_ready;
    logic [1:0]  clk_o;
    logic [1:0]  tick_o;

    logic [2:0]  ch_en3 = 3'b111;
    logic        cfg_valid3;
    logic [1:0]  cfg_ch3;
    logic [15:0] cfg_div3;
    logic        cfg_ready3;
    logic [2:0]  clk_o3;
    logic [2:0]  tick_o3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk_100 = ~clk_100;

    clk_div_multi u_dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    clk_div_multi #(.NUM_CH(3)) u_dut3 (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .ch_en     (ch_en3),
        .sync      (sync),
        .cfg_valid (cfg_valid3),
        .cfg_ch    (cfg_ch3),
        .cfg_div   (cfg_div3),
        .cfg_ready (cfg_ready3),
        .clk_o     (clk_o3),
        .tick_o    (tick_o3)
    );

    task automatic tk();
        @(posedge clk_100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Both channels at divisor 1 starting from cnt=0: rise on edge 2, period 4.
    task automatic run_div1(input string tag, input int n, input bit with3);
        logic [1:0] ec, et;
        for (int k = 1; k <= n; k++) begin
            tk();
            ec = (k >= 2 && ((k - 2) % 4) < 2) ? 2'b11 : 2'b00;
            et = (k >= 2 && ((k - 2) % 4) == 0) ? 2'b11 : 2'b00;
            chk($sformatf("%s_clk_e%0d", tag, k), 32'(clk_o), 32'(ec));
            chk($sformatf("%s_tick_e%0d", tag, k), 32'(tick_o), 32'(et));
            if (with3)
                chk($sformatf("%s_clk3_e%0d", tag, k), 32'(clk_o3), (ec[0] ? 32'h7 : 32'h0));
        end
    endtask

    logic [1:0] t2_clk [0:10];
    logic [1:0] t2_tck [0:10];
    logic       t3_clk [0:13];
    logic       t3_tck [0:13];
    logic       t3_rdy [0:13];
    logic       e0c, e0t, e1c, e1t;

    initial begin
        t2_clk = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        t2_tck = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
        t3_clk = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        t3_tck = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        t3_rdy = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1};

        rst_n = 1'b0; ch_en = 2'b11; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
        cfg_valid3 = 1'b0; cfg_ch3 = 2'd0; cfg_div3 = '0;

        // Reset state, then default divisor after release
        repeat (3) tk();
        chk("rst_clk", 32'(clk_o), 32'h0);
        chk("rst_tick", 32'(tick_o), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;
        run_div1("t1", 12, 1'b1);

        // ch0 -> divisor 0 while running; applied at the current period end
        sync = 1'b1; tk(); sync = 1'b0;
        chk("t2_sync_clk", 32'(clk_o), 32'h0);
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd0;
        for (int e = 1; e <= 11; e++) begin
            tk();
            if (e == 1) cfg_valid = 1'b0;
            chk($sformatf("t2_clk_e%0d", e), 32'(clk_o), 32'(t2_clk[e-1]));
            chk($sformatf("t2_tick_e%0d", e), 32'(tick_o), 32'(t2_tck[e-1]));
            chk($sformatf("t2_ready_e%0d", e), 32'(cfg_ready), (e <= 3) ? 32'h0 : 32'h1);
        end

        // Disabled ch1 takes divisor 3 in one cycle
        ch_en = 2'b01; cfg_ch = 1'b1; cfg_div = 16'd3; cfg_valid = 1'b1;
        tk();
        cfg_valid = 1'b0;
        chk("t3_dis_ready0", 32'(cfg_ready), 32'h0);
        chk("t3_dis_clk1", 32'(clk_o[1]), 32'h0);
        tk();
        chk("t3_dis_ready1", 32'(cfg_ready), 32'h1);

        // ch1 period 8, reload to 1 mid-high, back-to-back write stalls
        ch_en = 2'b10; sync = 1'b1; tk(); sync = 1'b0;
        chk("t3_sync_clk", 32'(clk_o), 32'h0);
        for (int e = 1; e <= 14; e++) begin
            if (e == 7) begin cfg_valid = 1'b1; cfg_div = 16'd1; end
            tk();
            if (e == 9) cfg_valid = 1'b0;
            chk($sformatf("t3_clk_e%0d", e), 32'(clk_o), 32'({t3_clk[e-1], 1'b0}));
            chk($sformatf("t3_tick1_e%0d", e), 32'(tick_o[1]), 32'(t3_tck[e-1]));
            chk($sformatf("t3_ready_e%0d", e), 32'(cfg_ready), 32'(t3_rdy[e-1]));
        end

        // Drop enable while high; re-enable timing with divisor 2
        ch_en = 2'b11; sync = 1'b1; tk(); sync = 1'b0;
        tk();
        chk("t4_rise_div0", 32'(clk_o[0]), 32'h1);
        ch_en = 2'b10; tk();
        chk("t4_off_clk", 32'(clk_o[0]), 32'h0);
        chk("t4_off_tick", 32'(tick_o[0]), 32'h0);
        cfg_ch = 1'b0; cfg_div = 16'd2; cfg_valid = 1'b1; tk();
        cfg_valid = 1'b0;
        chk("t4_wr_ready0", 32'(cfg_ready), 32'h0);
        tk();
        chk("t4_wr_ready1", 32'(cfg_ready), 32'h1);
        ch_en = 2'b11; tk(); tk();
        chk("t4_reen_lo", 32'(clk_o[0]), 32'h0);
        tk();
        chk("t4_reen_rise", 32'(clk_o[0]), 32'h1);
        chk("t4_reen_tick", 32'(tick_o[0]), 32'h1);
        tk();
        chk("t4_high", 32'(clk_o[0]), 32'h1);
        chk("t4_high_tick", 32'(tick_o[0]), 32'h0);
        ch_en = 2'b10; tk();
        chk("t4_drop_clk", 32'(clk_o[0]), 32'h0);
        chk("t4_drop_tick", 32'(tick_o[0]), 32'h0);

        // ch1 -> 4 pending, then sync applies it and aligns div 2 / div 4
        ch_en = 2'b11; cfg_ch = 1'b1; cfg_div = 16'd4; cfg_valid = 1'b1;
        tk();
        cfg_valid = 1'b0; sync = 1'b1; tk(); sync = 1'b0;
        chk("t5_sync_clk", 32'(clk_o), 32'h0);
        chk("t5_sync_tick", 32'(tick_o), 32'h0);
        chk("t5_sync_ready", 32'(cfg_ready), 32'h1);
        for (int e = 1; e <= 16; e++) begin
            tk();
            e0c = (e >= 3) && (((e - 3) % 6) < 3);
            e0t = (e >= 3) && (((e - 3) % 6) == 0);
            e1c = (e >= 5) && (((e - 5) % 10) < 5);
            e1t = (e >= 5) && (((e - 5) % 10) == 0);
            chk($sformatf("t5_clk_e%0d", e), 32'(clk_o), 32'({e1c, e0c}));
            chk($sformatf("t5_tick_e%0d", e), 32'(tick_o), 32'({e1t, e0t}));
        end

        // Pending write on ch0, then reset mid-high discards it
        cfg_ch = 1'b0; cfg_div = 16'd5; cfg_valid = 1'b1;
        tk();
        cfg_valid = 1'b0;
        chk("t6_pend_ready", 32'(cfg_ready), 32'h0);
        chk("t6_pend_high", 32'(clk_o[0]), 32'h1);
        rst_n = 1'b0; tk();
        chk("t6_rst_clk", 32'(clk_o), 32'h0);
        chk("t6_rst_tick", 32'(tick_o), 32'h0);
        chk("t6_rst_ready", 32'(cfg_ready), 32'h1);
        rst_n = 1'b1;

        // Out-of-range channel on the 3-channel instance: accepted, no effect
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 16'd0;
        #1;
        chk("t6_oor_ready", 32'(cfg_ready3), 32'h1);
        run_div1("t6", 10, 1'b1);
        chk("t6_oor_ready_hold", 32'(cfg_ready3), 32'h1);
        cfg_ch3 = 2'd2; tk();
        cfg_valid3 = 1'b0;
        chk("t6_inr_ready", 32'(cfg_ready3), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock-divider generator running off the 100 MHz system clock.
- Each channel produces a 50%-duty divided square wave and a one-cycle tick strobe, usable as a clock enable for VGA/CPU/peripheral timing.
- The divisor of each channel is reloadable at runtime through a valid/ready config port.
- A new divisor takes effect only at a period boundary, so there are no runt pulses. A global sync input realigns all channels.

Parameters:
- NUM_CH, 2, number of independent divider channels (≥1).
- DIV_W, 16, width of the half-period divisor.
- DEFAULT_DIV, 1, divisor loaded on reset. Half-period = DEFAULT_DIV+1 input cycles.
- CH_W, derived as max(1, clog2(NUM_CH)), width of the channel select.

Ports:
- clk_100  in  1  system clock; the sole clock.
- rst_n  in  1  synchronous, active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle pulse; realigns all channels.
- cfg_valid  in  1  config write request.
- cfg_ch  in  CH_W  target channel.
- cfg_div  in  DIV_W  new half-period divisor.
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready.
- clk_o  out  NUM_CH  divided square waves (registered).
- tick_o  out  NUM_CH  one-cycle strobe, high in the cycle clk_o[i] rises.

Behaviour:
- Clocking and reset:
  - One clock, clk_100; reset rst_n is synchronous and active-low. All state updates on the rising edge of clk_100.
  - Reset has priority over everything.
  - Reset values: cnt=0, clk_o=0, tick_o=0, div_act=DEFAULT_DIV, pending=0, pend_div=0, for every channel.
- Per-channel state: cnt[DIV_W], div_act[DIV_W], pend_div[DIV_W], pending (1 bit), clk_o, tick_o.
- Output timing:
  - Output frequency = f_clk / (2·(div_act+1)).
  - div_act=0 gives a toggle every cycle (divide by 2).
- Enabled channel, sync=0:
  - If cnt >= div_act: cnt←0 and clk_o←~clk_o.
    - If clk_o was 0 (rising): tick_o←1.
    - If clk_o was 1 (falling, period end) and pending=1: div_act←pend_div, pending←0.
  - Else: cnt←cnt+1, tick_o←0.
  - The >= comparison guards against cnt > div_act; with boundary-only reloads this never occurs.
- Disabled channel (ch_en[i]=0):
  - cnt←0, clk_o←0, tick_o←0.
  - If pending=1, apply it immediately: div_act←pend_div, pending←0.
  - On re-enable, the first rise occurs after div_act+1 enabled cycles.
- sync=1:
  - Every channel: cnt←0, clk_o←0, tick_o←0; pending is applied immediately.
  - Channels enabled in the following cycles start in phase.
  - sync overrides counting and ch_en; sync is ignored during reset.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch], combinational from registered state.
  - cfg_ready = 1 when cfg_ch >= NUM_CH; such a write is accepted and silently dropped.
  - On accept: pend_div[cfg_ch]←cfg_div, pending←1.
  - One pending slot per channel. A second write to the same channel stalls (ready=0) until the apply cycle has passed; ready returns high the cycle after apply.
  - cfg_valid may be held; the initiator must keep cfg_ch/cfg_div stable until accepted.
- Boundary conditions:
  - Write arriving in the exact cycle of a period end: pending is registered, so the new value is captured after the edge and applied at the next period end, not the current one.
  - Reset mid-period or with a write pending: the pending write is discarded, div_act returns to DEFAULT_DIV, outputs go low in the cycle after the reset edge.
  - div change from large to small: the current period completes at the old length, with no shortened half-period.
  - cfg_div = 2^DIV_W−1: the counter saturates at compare with no wrap; half-period = 2^DIV_W cycles.
- Latency: a config accept is visible on clk_o at the first period end after the accept cycle. All outputs are registered; no combinational path from inputs to clk_o/tick_o.

Decomposition:
- Package clk_div_pkg: DIV_W default, DEFAULT_DIV default, clog2-based CH_W helper function.
- Sub-module clk_div_ch: one channel holding cnt/div_act/pend_div/pending/clk_o/tick_o, with inputs en, sync, load strobe, load value and output pending.
- Top clk_div_multi: generate-instantiates NUM_CH channels, decodes cfg_ch into per-channel load strobes, muxes pending into cfg_ready.

Test Plan:
1. NUM_CH=2, DEFAULT_DIV=1, rst_n low 3 cycles then high with ch_en=11 → both clk_o rise on edge 2 after release, period 4 cycles, tick_o high 1 cycle every 4, coincident with the rise.
2. Write ch0 div=0 with ch_en=01 → after the current period ends, clk_o[0] toggles every cycle (50 MHz) and tick_o[0] pulses every 2nd cycle; ch1 is unaffected.
3. ch1 running div=3 (period 8): write div=1 in the 3rd cycle of the high half → that period still lasts 8 cycles, then period 4; cfg_ready for ch1 is 0 from accept until the cycle after apply; a back-to-back second write stalls.
4. Drop ch_en[0] while clk_o[0]=1 → clk_o[0]=0 on the next edge with no tick; re-enable → first rise after div_act+1 cycles; a write to the disabled channel applies in 1 cycle.
5. Channels at div=2 and div=4 with arbitrary phase, pulse sync → both clk_o=0 next cycle; rises at +3 and +5 cycles, then periodic 6/10.
6. Pending write on ch0 plus rst_n low for 1 cycle mid-high → clk_o=00, cfg_ready=1, div_act back to DEFAULT_DIV (period 4); cfg_ch=3 write → accepted, no channel changes.
